envelope_adsr_shaper: RTL

//  ADSR amplitude envelope stage placed directly downstream of the 32 kHz sine generator.

---
 rtl/envelope_adsr_shaper_if.sv | 21 ++
 rtl/envelope_adsr_shaper.sv | 124 ++++++++++++
 2 files changed

// File: rtl/envelope_adsr_shaper_if.sv
// Signal bundle between the sine generator / note control and the ADSR envelope shaper.
interface envelope_adsr_shaper_if;
   logic       gate;
   logic [7:0] inputSample;
   logic [7:0] sustainLevel;
   logic [7:0] outputSample;
   logic [7:0] envelopeLevel;
   logic [2:0] stage;
   logic       active;
   logic       noteDone;

   modport master (
      output gate, inputSample, sustainLevel,
      input  outputSample, envelopeLevel, stage, active, noteDone
   );

   modport slave (
      input  gate, inputSample, sustainLevel,
      output outputSample, envelopeLevel, stage, active, noteDone
   );
endinterface

// File: rtl/envelope_adsr_shaper.sv
// ADSR amplitude envelope applied to the 8-bit sine generator sample.
// The level steps at a per-stage divided rate and scales the sample one clock later.
module envelope_adsr_shaper #(
   parameter int unsigned ATTACK_DIV  = 32,
   parameter int unsigned DECAY_DIV   = 64,
   parameter int unsigned RELEASE_DIV = 128,
   parameter int unsigned DIV_W       = 16
) (
   input  logic                   CLK_32KHz,
   input  logic                   reset_n,
   envelope_adsr_shaper_if.slave  env
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } stage_t;

   stage_t           stageReg, stageNext;
   logic [7:0]       levelReg, levelNext;
   logic [DIV_W-1:0] divReg, divNext, divLimit;
   logic             divStep;
   logic [7:0]       outReg, outNext;
   logic             doneReg, doneNext;
   logic             activeReg;

   // Stages without a ramp use a limit of zero, which keeps the divider parked at 0.
   always_comb begin
      divLimit = '0;
      case (stageReg)
         ATTACK:  divLimit = DIV_W'(ATTACK_DIV - 1);
         DECAY:   divLimit = DIV_W'(DECAY_DIV - 1);
         RELEASE: divLimit = DIV_W'(RELEASE_DIV - 1);
         default: divLimit = '0;
      endcase
   end

   assign divStep = (divReg == divLimit);

   // (level+1) scaling lets full scale pass the sample untouched and zero silence it.
   assign outNext = 8'((17'(env.inputSample) * (17'(levelReg) + 17'd1)) >> 8);

   always_comb begin
      stageNext = stageReg;
      levelNext = levelReg;
      doneNext  = 1'b0;
      divNext   = divStep ? '0 : divReg + DIV_W'(1);
      case (stageReg)
         IDLE: begin
            if (env.gate) begin
               stageNext = ATTACK;
               levelNext = 8'd0;
            end
         end
         ATTACK: begin
            if (!env.gate)
               stageNext = RELEASE;
            else if (levelReg == 8'd255)
               stageNext = DECAY;
            else if (divStep)
               levelNext = levelReg + 8'd1;
         end
         DECAY: begin
            if (!env.gate)
               stageNext = RELEASE;
            else if (levelReg <= env.sustainLevel) begin
               stageNext = SUSTAIN;
               levelNext = env.sustainLevel;
            end else if (divStep)
               levelNext = levelReg - 8'd1;
         end
         SUSTAIN: begin
            if (!env.gate)
               stageNext = RELEASE;
            else
               levelNext = env.sustainLevel;
         end
         RELEASE: begin
            // A new gate restarts the attack from the current level so there is no click.
            if (env.gate)
               stageNext = ATTACK;
            else if (levelReg == 8'd0) begin
               stageNext = IDLE;
               doneNext  = 1'b1;
            end else if (divStep)
               levelNext = levelReg - 8'd1;
         end
         default: begin
            stageNext = IDLE;
            levelNext = 8'd0;
         end
      endcase
      if (stageNext != stageReg)
         divNext = '0;
   end

   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         stageReg  <= IDLE;
         levelReg  <= 8'd0;
         divReg    <= '0;
         outReg    <= 8'd0;
         doneReg   <= 1'b0;
         activeReg <= 1'b0;
      end else begin
         stageReg  <= stageNext;
         levelReg  <= levelNext;
         divReg    <= divNext;
         outReg    <= outNext;
         doneReg   <= doneNext;
         activeReg <= (stageNext != IDLE);
      end
   end

   assign env.outputSample  = outReg;
   assign env.envelopeLevel = levelReg;
   assign env.stage         = stageReg;
   assign env.active        = activeReg;
   assign env.noteDone      = doneReg;

endmodule
